// File: rtl/axi_lite_arbiter.sv
// rtl/axi_lite_arbiter.sv - two-master (IFU/LSU) to one-slave AXI-lite arbiter, fixed priority
module axi_lite_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    // IFU read master
    input  logic                ifu_arvalid,
    input  logic [ADDR_W-1:0]   ifu_araddr,
    input  logic [2:0]          ifu_arsize,
    output logic                ifu_arready,
    output logic                ifu_rvalid,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic [1:0]          ifu_rresp,
    input  logic                ifu_rready,
    // LSU read master
    input  logic                lsu_arvalid,
    input  logic [ADDR_W-1:0]   lsu_araddr,
    input  logic [2:0]          lsu_arsize,
    output logic                lsu_arready,
    output logic                lsu_rvalid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic [1:0]          lsu_rresp,
    input  logic                lsu_rready,
    // LSU write master
    input  logic                lsu_awvalid,
    input  logic [ADDR_W-1:0]   lsu_awaddr,
    input  logic [2:0]          lsu_awsize,
    output logic                lsu_awready,
    input  logic                lsu_wvalid,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wstrb,
    input  logic                lsu_wlast,
    output logic                lsu_wready,
    output logic                lsu_bvalid,
    output logic [1:0]          lsu_bresp,
    input  logic                lsu_bready,
    // slave port
    output logic                s_arvalid,
    output logic [ADDR_W-1:0]   s_araddr,
    output logic [2:0]          s_arsize,
    input  logic                s_arready,
    output logic                s_awvalid,
    output logic [ADDR_W-1:0]   s_awaddr,
    output logic [2:0]          s_awsize,
    input  logic                s_awready,
    output logic                s_wvalid,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    output logic                s_wlast,
    input  logic                s_wready,
    input  logic                s_rvalid,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic [1:0]          s_rresp,
    output logic                s_rready,
    input  logic                s_bvalid,
    input  logic [1:0]          s_bresp,
    output logic                s_bready,
    output logic [1:0]          grant
);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        G_IFU_R = 2'b01,
        G_LSU_R = 2'b10,
        G_LSU_W = 2'b11
    } state_e;

    state_e state_q, state_d;
    logic   ar_done_q, ar_done_d;
    logic   aw_done_q, aw_done_d;
    logic   w_done_q,  w_done_d;

    assign grant = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ar_done_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ar_done_q <= ar_done_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ar_done_d   = ar_done_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        ifu_arready = 1'b0;
        ifu_rvalid  = 1'b0;
        ifu_rdata   = '0;
        ifu_rresp   = 2'b00;
        lsu_arready = 1'b0;
        lsu_rvalid  = 1'b0;
        lsu_rdata   = '0;
        lsu_rresp   = 2'b00;
        lsu_awready = 1'b0;
        lsu_wready  = 1'b0;
        lsu_bvalid  = 1'b0;
        lsu_bresp   = 2'b00;
        s_arvalid   = 1'b0;
        s_araddr    = '0;
        s_arsize    = 3'b000;
        s_awvalid   = 1'b0;
        s_awaddr    = '0;
        s_awsize    = 3'b000;
        s_wvalid    = 1'b0;
        s_wdata     = '0;
        s_wstrb     = '0;
        s_wlast     = 1'b0;
        s_rready    = 1'b0;
        s_bready    = 1'b0;

        unique case (state_q)
            IDLE: begin
                ar_done_d = 1'b0;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                if (lsu_awvalid || lsu_wvalid)  state_d = G_LSU_W;
                else if (lsu_arvalid)           state_d = G_LSU_R;
                else if (ifu_arvalid)           state_d = G_IFU_R;
            end
            G_IFU_R: begin
                s_arvalid   = ifu_arvalid & ~ar_done_q;
                s_araddr    = ifu_araddr;
                s_arsize    = ifu_arsize;
                ifu_arready = s_arready & ~ar_done_q;
                ifu_rvalid  = s_rvalid;
                ifu_rdata   = s_rdata;
                ifu_rresp   = s_rresp;
                s_rready    = ifu_rready;
                if (ifu_arvalid && s_arready) ar_done_d = 1'b1;
                if (s_rvalid && ifu_rready)   state_d   = IDLE;
            end
            G_LSU_R: begin
                s_arvalid   = lsu_arvalid & ~ar_done_q;
                s_araddr    = lsu_araddr;
                s_arsize    = lsu_arsize;
                lsu_arready = s_arready & ~ar_done_q;
                lsu_rvalid  = s_rvalid;
                lsu_rdata   = s_rdata;
                lsu_rresp   = s_rresp;
                s_rready    = lsu_rready;
                if (lsu_arvalid && s_arready) ar_done_d = 1'b1;
                if (s_rvalid && lsu_rready)   state_d   = IDLE;
            end
            G_LSU_W: begin
                // AW and W complete independently; each is masked once accepted
                s_awvalid   = lsu_awvalid & ~aw_done_q;
                s_awaddr    = lsu_awaddr;
                s_awsize    = lsu_awsize;
                lsu_awready = s_awready & ~aw_done_q;
                s_wvalid    = lsu_wvalid & ~w_done_q;
                s_wdata     = lsu_wdata;
                s_wstrb     = lsu_wstrb;
                s_wlast     = lsu_wlast;
                lsu_wready  = s_wready & ~w_done_q;
                lsu_bvalid  = s_bvalid;
                lsu_bresp   = s_bresp;
                s_bready    = lsu_bready;
                if (lsu_awvalid && s_awready) aw_done_d = 1'b1;
                if (lsu_wvalid && s_wready)   w_done_d  = 1'b1;
                if (s_bvalid && lsu_bready)   state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// tb/tb_axi_lite_arbiter.sv - directed self-checking bench for axi_lite_arbiter
module tb_axi_lite_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_arvalid;
    logic [31:0] ifu_araddr;
    logic [2:0]  ifu_arsize;
    logic        ifu_arready, ifu_rvalid;
    logic [31:0] ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        ifu_rready;
    logic        lsu_arvalid;
    logic [31:0] lsu_araddr;
    logic [2:0]  lsu_arsize;
    logic        lsu_arready, lsu_rvalid;
    logic [31:0] lsu_rdata;
    logic [1:0]  lsu_rresp;
    logic        lsu_rready;
    logic        lsu_awvalid;
    logic [31:0] lsu_awaddr;
    logic [2:0]  lsu_awsize;
    logic        lsu_awready;
    logic        lsu_wvalid;
    logic [31:0] lsu_wdata;
    logic [3:0]  lsu_wstrb;
    logic        lsu_wlast;
    logic        lsu_wready, lsu_bvalid;
    logic [1:0]  lsu_bresp;
    logic        lsu_bready;
    logic        s_arvalid;
    logic [31:0] s_araddr;
    logic [2:0]  s_arsize;
    logic        s_arready;
    logic        s_awvalid;
    logic [31:0] s_awaddr;
    logic [2:0]  s_awsize;
    logic        s_awready;
    logic        s_wvalid;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_wlast;
    logic        s_wready;
    logic        s_rvalid;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rready;
    logic        s_bvalid;
    logic [1:0]  s_bresp;
    logic        s_bready;
    logic [1:0]  grant;

    int compared   = 0;
    int mismatched = 0;

    axi_lite_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr), .ifu_arsize(ifu_arsize),
        .ifu_arready(ifu_arready), .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
        .ifu_rresp(ifu_rresp), .ifu_rready(ifu_rready),
        .lsu_arvalid(lsu_arvalid), .lsu_araddr(lsu_araddr), .lsu_arsize(lsu_arsize),
        .lsu_arready(lsu_arready), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
        .lsu_rresp(lsu_rresp), .lsu_rready(lsu_rready),
        .lsu_awvalid(lsu_awvalid), .lsu_awaddr(lsu_awaddr), .lsu_awsize(lsu_awsize),
        .lsu_awready(lsu_awready), .lsu_wvalid(lsu_wvalid), .lsu_wdata(lsu_wdata),
        .lsu_wstrb(lsu_wstrb), .lsu_wlast(lsu_wlast), .lsu_wready(lsu_wready),
        .lsu_bvalid(lsu_bvalid), .lsu_bresp(lsu_bresp), .lsu_bready(lsu_bready),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arsize(s_arsize), .s_arready(s_arready),
        .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awsize(s_awsize), .s_awready(s_awready),
        .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_wready(s_wready), .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_rready(s_rready), .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
        .grant(grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        ifu_arvalid = 0; ifu_araddr = 0; ifu_arsize = 0; ifu_rready = 0;
        lsu_arvalid = 0; lsu_araddr = 0; lsu_arsize = 0; lsu_rready = 0;
        lsu_awvalid = 0; lsu_awaddr = 0; lsu_awsize = 0;
        lsu_wvalid = 0; lsu_wdata = 0; lsu_wstrb = 0; lsu_wlast = 0; lsu_bready = 0;
        s_arready = 0; s_awready = 0; s_wready = 0;
        s_rvalid = 0; s_rdata = 0; s_rresp = 0; s_bvalid = 0; s_bresp = 0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        tick();
        chk("reset_grant", grant, 2'b00);
        chk("reset_s_arvalid", s_arvalid, 1'b0);
        rst = 1'b0;

        // IFU read alone
        tick();
        ifu_arvalid = 1; ifu_araddr = 32'h8000_0000; ifu_arsize = 3'd2; s_arready = 1;
        settle();
        chk("t1_idle_grant", grant, 2'b00);
        chk("t1_idle_s_arvalid", s_arvalid, 1'b0);
        tick();
        chk("t1_grant", grant, 2'b01);
        chk("t1_s_arvalid", s_arvalid, 1'b1);
        chk("t1_s_araddr", s_araddr, 32'h8000_0000);
        chk("t1_ifu_arready", ifu_arready, 1'b1);
        tick();
        s_rvalid = 1; s_rdata = 32'h0000_0413; ifu_rready = 1;
        settle();
        chk("t1_second_ar_blocked", s_arvalid, 1'b0);
        chk("t1_second_arready", ifu_arready, 1'b0);
        chk("t1_ifu_rvalid", ifu_rvalid, 1'b1);
        chk("t1_ifu_rdata", ifu_rdata, 32'h0000_0413);
        chk("t1_s_rready", s_rready, 1'b1);
        tick();
        clear_inputs();
        settle();
        chk("t1_release_grant", grant, 2'b00);
        chk("t1_idle_s_araddr", s_araddr, 32'h0);

        // IFU/LSU read collision
        ifu_arvalid = 1; ifu_araddr = 32'h8000_0010;
        lsu_arvalid = 1; lsu_araddr = 32'h0F00_0004; s_arready = 1;
        tick();
        chk("t2_grant_lsu", grant, 2'b10);
        chk("t2_s_araddr", s_araddr, 32'h0F00_0004);
        chk("t2_lsu_arready", lsu_arready, 1'b1);
        chk("t2_ifu_arready_a", ifu_arready, 1'b0);
        tick();
        lsu_arvalid = 0; s_rvalid = 1; s_rdata = 32'hDEAD_BEEF; s_rresp = 2'b01; lsu_rready = 1;
        settle();
        chk("t2_lsu_rvalid", lsu_rvalid, 1'b1);
        chk("t2_lsu_rdata", lsu_rdata, 32'hDEAD_BEEF);
        chk("t2_lsu_rresp", lsu_rresp, 2'b01);
        chk("t2_ifu_rvalid", ifu_rvalid, 1'b0);
        chk("t2_ifu_arready_b", ifu_arready, 1'b0);
        tick();
        s_rvalid = 0; s_rresp = 0; lsu_rready = 0;
        settle();
        chk("t2_bubble_grant", grant, 2'b00);
        chk("t2_bubble_s_arvalid", s_arvalid, 1'b0);
        tick();
        chk("t2_grant_ifu", grant, 2'b01);
        chk("t2_ifu_s_araddr", s_araddr, 32'h8000_0010);
        tick();
        ifu_arvalid = 0; s_rvalid = 1; ifu_rready = 1;
        tick();
        clear_inputs();
        settle();
        chk("t2_end_grant", grant, 2'b00);

        // LSU write, W before AW
        lsu_wvalid = 1; lsu_wdata = 32'h00AB_0000; lsu_wstrb = 4'b0100; lsu_wlast = 1;
        s_wready = 1; s_awready = 1;
        tick();
        chk("t3_grant", grant, 2'b11);
        chk("t3_lsu_wready_t1", lsu_wready, 1'b1);
        chk("t3_s_wvalid", s_wvalid, 1'b1);
        chk("t3_s_wdata", s_wdata, 32'h00AB_0000);
        chk("t3_s_wstrb", s_wstrb, 4'b0100);
        chk("t3_s_awvalid_idle", s_awvalid, 1'b0);
        tick();
        chk("t3_no_second_w", s_wvalid, 1'b0);
        chk("t3_wready_masked", lsu_wready, 1'b0);
        tick();
        lsu_wvalid = 0; lsu_awvalid = 1; lsu_awaddr = 32'h1000_0008;
        settle();
        chk("t3_s_awvalid", s_awvalid, 1'b1);
        chk("t3_s_awaddr", s_awaddr, 32'h1000_0008);
        chk("t3_lsu_awready", lsu_awready, 1'b1);
        tick();
        lsu_awvalid = 0; s_bvalid = 1; s_bresp = 2'b00; lsu_bready = 1;
        settle();
        chk("t3_lsu_bvalid", lsu_bvalid, 1'b1);
        chk("t3_s_bready", s_bready, 1'b1);
        tick();
        clear_inputs();
        settle();
        chk("t3_end_grant", grant, 2'b00);

        // write beats IFU read
        lsu_awvalid = 1; lsu_awaddr = 32'h2000_0000; lsu_wvalid = 1; lsu_wdata = 32'h1234_5678;
        lsu_wstrb = 4'hF; lsu_wlast = 1; ifu_arvalid = 1; ifu_araddr = 32'h8000_0020;
        s_awready = 1; s_wready = 1; s_arready = 1;
        tick();
        chk("t4_grant", grant, 2'b11);
        chk("t4_s_arvalid", s_arvalid, 1'b0);
        chk("t4_ifu_arready_a", ifu_arready, 1'b0);
        chk("t4_s_awvalid", s_awvalid, 1'b1);
        chk("t4_s_wvalid", s_wvalid, 1'b1);
        tick();
        lsu_awvalid = 0; lsu_wvalid = 0; s_bvalid = 1; s_bresp = 2'b10; lsu_bready = 1;
        settle();
        chk("t4_lsu_bresp", lsu_bresp, 2'b10);
        chk("t4_ifu_arready_b", ifu_arready, 1'b0);
        tick();
        s_bvalid = 0; s_bresp = 0; lsu_bready = 0;
        settle();
        chk("t4_bubble_grant", grant, 2'b00);
        tick();
        chk("t4_grant_ifu", grant, 2'b01);
        chk("t4_ifu_s_araddr", s_araddr, 32'h8000_0020);

        // reset while the IFU read response is pending
        tick();
        ifu_arvalid = 0; s_rvalid = 1; s_rdata = 32'hCAFE_0001;
        settle();
        chk("t5_pending_rvalid", ifu_rvalid, 1'b1);
        rst = 1;
        settle();
        chk("t5_rst_grant", grant, 2'b00);
        chk("t5_rst_ifu_rvalid", ifu_rvalid, 1'b0);
        chk("t5_rst_s_rready", s_rready, 1'b0);
        chk("t5_rst_ifu_rdata", ifu_rdata, 32'h0);
        tick();
        rst = 0;
        clear_inputs();
        ifu_arvalid = 1; ifu_araddr = 32'h8000_0100; s_arready = 1;
        tick();
        chk("t5_regrant", grant, 2'b01);
        chk("t5_s_arvalid", s_arvalid, 1'b1);
        chk("t5_ifu_arready", ifu_arready, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/axi_lite_arbiter.md
# axi_lite_arbiter

- Two-master, one-slave AXI-lite arbiter that shares the single core memory port between instruction fetch (IFU) and load/store (LSU).
- Grants exactly one transaction at a time. The grant is held from request to response handshake, and all channel signals are forwarded combinationally from the granted master.
- It sits between the IFU/LSU AXI-lite masters and the crossbar/SoC bus.
- Fixed priority: LSU write > LSU read > IFU read.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (wstrb is DATA_W/8)

Ports (reset rst, asynchronous, active-high; clock clk):
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- ifu_arvalid / ifu_araddr / ifu_arsize  input  1 / ADDR_W / 3  IFU read address
- ifu_arready  output  1  IFU read address accepted
- ifu_rvalid / ifu_rdata / ifu_rresp  output  1 / DATA_W / 2  IFU read response
- ifu_rready  input  1  IFU response accept
- lsu_arvalid / lsu_araddr / lsu_arsize  input  1 / ADDR_W / 3  LSU read address
- lsu_arready  output  1  LSU read address accepted
- lsu_rvalid / lsu_rdata / lsu_rresp  output  1 / DATA_W / 2  LSU read response
- lsu_rready  input  1  LSU response accept
- lsu_awvalid / lsu_awaddr / lsu_awsize  input  1 / ADDR_W / 3  LSU write address
- lsu_awready  output  1  LSU write address accepted
- lsu_wvalid / lsu_wdata / lsu_wstrb / lsu_wlast  input  1 / DATA_W / DATA_W/8 / 1  LSU write data
- lsu_wready  output  1  LSU write data accepted
- lsu_bvalid / lsu_bresp  output  1 / 2  LSU write response
- lsu_bready  input  1  LSU write response accept
- s_ar* / s_aw* / s_w*  output  mirror widths  slave request channels (valid, addr, size, data, strb, last)
- s_arready / s_awready / s_wready  input  1  slave request accepts
- s_r* / s_b*  input  mirror widths  slave responses (valid, data, resp)
- s_rready / s_bready  output  1  slave response accepts
- grant  output  2  current owner: 00 none, 01 IFU read, 10 LSU read, 11 LSU write

## Operation
- FSM states: IDLE, G_IFU_R, G_LSU_R, G_LSU_W. The state register is grant.
- IDLE transitions, evaluated at the clock edge:
  - lsu_awvalid | lsu_wvalid -> G_LSU_W
  - else lsu_arvalid -> G_LSU_R
  - else ifu_arvalid -> G_IFU_R
  - else stay in IDLE.
- G_IFU_R and G_LSU_R:
  - Forward ar*/arready and r*/rready between the owner and the slave.
  - Exit to IDLE on the cycle s_rvalid & s_rready.
- G_LSU_W:
  - Forward aw*, w*, b* between LSU and slave.
  - AW and W handshakes may complete in either order or together.
  - Exit to IDLE on the cycle s_bvalid & s_bready.
- Non-owner and IDLE behaviour:
  - A non-owner sees arready/awready/wready/rvalid/bvalid = 0.
  - In IDLE, all slave-side valids and readys are 0; address/data outputs are 0.
- rresp and bresp pass through unchanged. Error responses do not alter arbitration.
- No reordering and no outstanding-transaction counting: the slave is assumed single-outstanding. A second AR from the owner before its R handshake is not forwarded (arready held 0 after the first AR handshake, tracked by an ar_done flag; likewise aw_done and w_done).
- Reset:
  - Asynchronously forces IDLE and clears all done flags.
  - All outputs are 0 during reset, including mid-transaction. The slave must be reset together with the arbiter.

## Timing
- Arbitration latency: a request is visible at the slave one cycle after it is first asserted in IDLE. The grant registers at the edge; forwarding is combinational thereafter.
- Release: one mandatory IDLE cycle after each response handshake. Back-to-back transactions therefore have a 1-cycle bubble, plus 1 cycle of arbitration.
- Masters must hold valid and payload stable until their handshake (AXI rule). The arbiter does not latch payload.
- Starvation: the IFU can be starved only by continuous LSU traffic. The core issues at most one LSU access per instruction, so this is bounded.
- Simultaneous events in IDLE:
  - IFU AR and LSU AR in the same cycle: LSU wins. IFU arvalid stays pending and is granted after LSU completion plus the IDLE bubble.
  - LSU aw/w and LSU ar together: write wins.

## Test plan
1. IFU read alone: ifu_arvalid=1, araddr=0x8000_0000. Required: grant=01 next cycle; s_araddr=0x8000_0000; slave returns rdata=0x0000_0413 -> ifu_rdata=0x0000_0413, ifu_rvalid=1; grant=00 the following cycle.
2. Collision: ifu_arvalid and lsu_arvalid (0x0F00_0004) asserted in the same cycle. Required: grant=10 first with lsu_rdata forwarded and ifu_arready=0 throughout; then IDLE one cycle; then grant=01.
3. LSU write with W before AW: wvalid at t0, awvalid at t3, wstrb=0b0100, wdata=0x00AB_0000, slave wready=1. Required: lsu_wready at t1, no second W forwarded; bvalid -> lsu_bvalid, then grant=00.
4. Write/read priority: lsu_awvalid=1 and ifu_arvalid=1 together. Required: grant=11 with IFU blocked until bresp; slave bresp=2'b10 passes to lsu_bresp=2'b10.
5. Reset mid-read: assert rst while grant=01 and s_rvalid is pending. Required: immediately grant=00 and all valid/ready outputs 0; after deassert, a fresh ifu_arvalid is granted normally.
